// File: rtl/decode_regread_if.sv
// Signal bundle between the fetch/forwarding sources and the decode/register-read stage.
// The master drives the D register, register file and forwarding taps; the slave returns the E register.
interface decode_regread_if;
    logic [1:0]  D_stat;
    logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
    logic [63:0] D_valC, D_valP;
    logic [63:0] r0, r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, r11, r12, r13, r14;
    logic [3:0]  e_dstE;
    logic [63:0] e_valE;
    logic [3:0]  M_dstE, M_dstM;
    logic [63:0] M_valE, m_valM;
    logic [3:0]  W_dstE, W_dstM;
    logic [63:0] W_valE, W_valM;
    logic        E_bubble;
    logic [3:0]  d_srcA, d_srcB;
    logic [1:0]  E_stat;
    logic [3:0]  E_icode, E_ifun;
    logic [63:0] E_valC, E_valA, E_valB;
    logic [3:0]  E_dstE, E_dstM, E_srcA, E_srcB;

    modport master (
        output D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
        output r0, r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, r11, r12, r13, r14,
        output e_dstE, e_valE, M_dstE, M_dstM, M_valE, m_valM,
        output W_dstE, W_dstM, W_valE, W_valM, E_bubble,
        input  d_srcA, d_srcB, E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
        input  E_dstE, E_dstM, E_srcA, E_srcB
    );
    modport slave (
        input  D_stat, D_icode, D_ifun, D_rA, D_rB, D_valC, D_valP,
        input  r0, r1, r2, r3, r4, r5, r6, r7, r8, r9, r10, r11, r12, r13, r14,
        input  e_dstE, e_valE, M_dstE, M_dstM, M_valE, m_valM,
        input  W_dstE, W_dstM, W_valE, W_valM, E_bubble,
        output d_srcA, d_srcB, E_stat, E_icode, E_ifun, E_valC, E_valA, E_valB,
        output E_dstE, E_dstM, E_srcA, E_srcB
    );
endinterface

// File: rtl/decode_regread.sv
// Y86-64 decode stage: register ID decode, register read with E/M/W forwarding,
// and the E pipeline register with bubble insertion.
module decode_regread (
    input  logic              clock,
    input  logic              reset,
    decode_regread_if.slave   bus
);
    localparam logic [3:0] RNONE = 4'hF;
    localparam logic [3:0] RSP   = 4'h4;

    logic [3:0]        w_srcA, w_srcB, w_dstE, w_dstM;
    logic [63:0]       w_valA, w_valB;
    logic [15:0][63:0] w_rf;

    logic [1:0]  r_stat;
    logic [3:0]  r_icode, r_ifun, r_dstE, r_dstM, r_srcA, r_srcB;
    logic [63:0] r_valC, r_valA, r_valB;

    always_comb begin
        w_srcA = RNONE;
        w_srcB = RNONE;
        w_dstE = RNONE;
        w_dstM = RNONE;
        case (bus.D_icode)
            4'h2, 4'h4, 4'h6, 4'hA: w_srcA = bus.D_rA;
            4'h9, 4'hB:             w_srcA = RSP;
            default: ;
        endcase
        case (bus.D_icode)
            4'h4, 4'h5, 4'h6:       w_srcB = bus.D_rB;
            4'h8, 4'h9, 4'hA, 4'hB: w_srcB = RSP;
            default: ;
        endcase
        // cmov's dstE is left unconditioned; execute drops it if the condition fails
        case (bus.D_icode)
            4'h2, 4'h3, 4'h6:       w_dstE = bus.D_rB;
            4'h8, 4'h9, 4'hA, 4'hB: w_dstE = RSP;
            default: ;
        endcase
        case (bus.D_icode)
            4'h5, 4'hB: w_dstM = bus.D_rA;
            default: ;
        endcase
    end

    // Slot 15 is RNONE and reads as zero
    assign w_rf = {64'd0, bus.r14, bus.r13, bus.r12, bus.r11, bus.r10, bus.r9, bus.r8,
                   bus.r7, bus.r6, bus.r5, bus.r4, bus.r3, bus.r2, bus.r1, bus.r0};

    // r inputs are pre-write during this cycle, so W must be forwarded too
    always_comb begin
        w_valA = w_rf[w_srcA];
        if (bus.D_icode == 4'h7 || bus.D_icode == 4'h8) w_valA = bus.D_valP;
        else if (w_srcA != RNONE) begin
            if      (w_srcA == bus.e_dstE) w_valA = bus.e_valE;
            else if (w_srcA == bus.M_dstM) w_valA = bus.m_valM;
            else if (w_srcA == bus.M_dstE) w_valA = bus.M_valE;
            else if (w_srcA == bus.W_dstM) w_valA = bus.W_valM;
            else if (w_srcA == bus.W_dstE) w_valA = bus.W_valE;
        end
    end

    always_comb begin
        w_valB = w_rf[w_srcB];
        if (w_srcB != RNONE) begin
            if      (w_srcB == bus.e_dstE) w_valB = bus.e_valE;
            else if (w_srcB == bus.M_dstM) w_valB = bus.m_valM;
            else if (w_srcB == bus.M_dstE) w_valB = bus.M_valE;
            else if (w_srcB == bus.W_dstM) w_valB = bus.W_valM;
            else if (w_srcB == bus.W_dstE) w_valB = bus.W_valE;
        end
    end

    always_ff @(posedge clock) begin
        if (reset || bus.E_bubble) begin
            r_stat  <= 2'd0;
            r_icode <= 4'h1;
            r_ifun  <= 4'h0;
            r_valC  <= 64'd0;
            r_valA  <= 64'd0;
            r_valB  <= 64'd0;
            r_dstE  <= RNONE;
            r_dstM  <= RNONE;
            r_srcA  <= RNONE;
            r_srcB  <= RNONE;
        end else begin
            r_stat  <= bus.D_stat;
            r_icode <= bus.D_icode;
            r_ifun  <= bus.D_ifun;
            r_valC  <= bus.D_valC;
            r_valA  <= w_valA;
            r_valB  <= w_valB;
            r_dstE  <= w_dstE;
            r_dstM  <= w_dstM;
            r_srcA  <= w_srcA;
            r_srcB  <= w_srcB;
        end
    end

    assign bus.d_srcA  = w_srcA;
    assign bus.d_srcB  = w_srcB;
    assign bus.E_stat  = r_stat;
    assign bus.E_icode = r_icode;
    assign bus.E_ifun  = r_ifun;
    assign bus.E_valC  = r_valC;
    assign bus.E_valA  = r_valA;
    assign bus.E_valB  = r_valB;
    assign bus.E_dstE  = r_dstE;
    assign bus.E_dstM  = r_dstM;
    assign bus.E_srcA  = r_srcA;
    assign bus.E_srcB  = r_srcB;
endmodule

// File: tb/tb_decode_regread.sv
// Directed bench for decode_regread: reset/bubble contents, decode, register read and forwarding priority.
module tb_decode_regread;
    logic clock = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;

    decode_regread_if dif ();
    decode_regread dut (.clock(clock), .reset(reset), .bus(dif));

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change after negedge; the E register loads on posedge; sample on the next negedge
    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic set_insn(input logic [3:0] ic, input logic [3:0] fn,
                            input logic [3:0] ra, input logic [3:0] rb);
        dif.D_icode = ic;
        dif.D_ifun  = fn;
        dif.D_rA    = ra;
        dif.D_rB    = rb;
    endtask

    task automatic clr_fwd();
        dif.e_dstE = 4'hF; dif.M_dstE = 4'hF; dif.M_dstM = 4'hF;
        dif.W_dstE = 4'hF; dif.W_dstM = 4'hF;
    endtask

    task automatic chk_bubble(input string tag);
        chk({tag, ".stat"},  dif.E_stat,  2'd0);
        chk({tag, ".icode"}, dif.E_icode, 4'h1);
        chk({tag, ".ifun"},  dif.E_ifun,  4'h0);
        chk({tag, ".valC"},  dif.E_valC,  64'd0);
        chk({tag, ".valA"},  dif.E_valA,  64'd0);
        chk({tag, ".valB"},  dif.E_valB,  64'd0);
        chk({tag, ".dstE"},  dif.E_dstE,  4'hF);
        chk({tag, ".dstM"},  dif.E_dstM,  4'hF);
        chk({tag, ".srcA"},  dif.E_srcA,  4'hF);
        chk({tag, ".srcB"},  dif.E_srcB,  4'hF);
    endtask

    initial begin
        reset = 1'b1;
        dif.D_stat = 2'd0;
        set_insn(4'h1, 4'h0, 4'hF, 4'hF);
        dif.D_valC = 64'h0; dif.D_valP = 64'h0;
        {dif.r0, dif.r1, dif.r2, dif.r3, dif.r4, dif.r5, dif.r6, dif.r7} = '0;
        {dif.r8, dif.r9, dif.r10, dif.r11, dif.r12, dif.r13, dif.r14} = '0;
        dif.e_valE = '0; dif.M_valE = '0; dif.m_valM = '0; dif.W_valE = '0; dif.W_valM = '0;
        clr_fwd();
        dif.E_bubble = 1'b0;
        @(negedge clock);
        step();
        step();
        chk_bubble("reset");

        // OPq addq rA=2 rB=3
        reset = 1'b0;
        dif.r2 = 64'd5; dif.r3 = 64'd7;
        set_insn(4'h6, 4'h0, 4'h2, 4'h3);
        #1;
        chk("opq.d_srcA", dif.d_srcA, 4'h2);
        chk("opq.d_srcB", dif.d_srcB, 4'h3);
        step();
        chk("opq.icode", dif.E_icode, 4'h6);
        chk("opq.valA",  dif.E_valA,  64'd5);
        chk("opq.valB",  dif.E_valB,  64'd7);
        chk("opq.dstE",  dif.E_dstE,  4'h3);
        chk("opq.dstM",  dif.E_dstM,  4'hF);

        // Forward priority chain on srcA via rrmovq rA=2
        set_insn(4'h2, 4'h0, 4'h2, 4'h9);
        dif.e_dstE = 4'h2; dif.e_valE = 64'h11;
        dif.M_dstM = 4'h2; dif.m_valM = 64'h22;
        dif.M_dstE = 4'h2; dif.M_valE = 64'h44;
        dif.W_dstM = 4'h2; dif.W_valM = 64'h55;
        dif.W_dstE = 4'h2; dif.W_valE = 64'h33;
        step(); chk("fwd.e",   dif.E_valA, 64'h11);
        chk("cmov.dstE", dif.E_dstE, 4'h9);
        dif.e_dstE = 4'hF;
        step(); chk("fwd.Mm",  dif.E_valA, 64'h22);
        dif.M_dstM = 4'hF;
        step(); chk("fwd.ME",  dif.E_valA, 64'h44);
        dif.M_dstE = 4'hF;
        step(); chk("fwd.WM",  dif.E_valA, 64'h55);
        dif.W_dstM = 4'hF;
        step(); chk("fwd.WE",  dif.E_valA, 64'h33);
        dif.W_dstE = 4'hF;
        step(); chk("fwd.reg", dif.E_valA, 64'd5);

        // srcB forwarded from execute, srcA from register file; stat/ifun pass through
        dif.r7 = 64'h70; dif.r8 = 64'h80;
        dif.D_stat = 2'd2;
        set_insn(4'h6, 4'h3, 4'h7, 4'h8);
        dif.e_dstE = 4'h8; dif.e_valE = 64'h5A;
        step();
        chk("fwdB.valA", dif.E_valA, 64'h70);
        chk("fwdB.valB", dif.E_valB, 64'h5A);
        chk("fwdB.stat", dif.E_stat, 2'd2);
        chk("fwdB.ifun", dif.E_ifun, 4'h3);
        dif.D_stat = 2'd0;
        clr_fwd();

        // popq rA=0
        dif.r4 = 64'h100;
        set_insn(4'hB, 4'h0, 4'h0, 4'hF);
        step();
        chk("pop.srcA", dif.E_srcA, 4'h4);
        chk("pop.srcB", dif.E_srcB, 4'h4);
        chk("pop.valA", dif.E_valA, 64'h100);
        chk("pop.valB", dif.E_valB, 64'h100);
        chk("pop.dstE", dif.E_dstE, 4'h4);
        chk("pop.dstM", dif.E_dstM, 4'h0);

        // call: valA takes valP even though rsp is readable
        set_insn(4'h8, 4'h0, 4'hF, 4'hF);
        dif.D_valP = 64'h40; dif.D_valC = 64'h200;
        step();
        chk("call.valA", dif.E_valA, 64'h40);
        chk("call.srcA", dif.E_srcA, 4'hF);
        chk("call.srcB", dif.E_srcB, 4'h4);
        chk("call.valB", dif.E_valB, 64'h100);
        chk("call.valC", dif.E_valC, 64'h200);

        // irmovq with RNONE source and W_dstE also RNONE
        set_insn(4'h3, 4'h0, 4'hF, 4'h1);
        dif.W_dstE = 4'hF; dif.W_valE = 64'h99; dif.D_valC = 64'h77;
        step();
        chk("rnone.srcA", dif.E_srcA, 4'hF);
        chk("rnone.valA", dif.E_valA, 64'd0);
        chk("rnone.valB", dif.E_valB, 64'd0);
        chk("rnone.dstE", dif.E_dstE, 4'h1);
        chk("rnone.valC", dif.E_valC, 64'h77);

        // rmmovq with bubble requested, then loaded, then reset+bubble together
        set_insn(4'h4, 4'h0, 4'h1, 4'h2);
        dif.r1 = 64'h1111; dif.r2 = 64'h2222;
        dif.E_bubble = 1'b1;
        step();
        chk_bubble("bubble");
        dif.E_bubble = 1'b0;
        step();
        chk("rm.icode", dif.E_icode, 4'h4);
        chk("rm.dstE",  dif.E_dstE,  4'hF);
        chk("rm.valA",  dif.E_valA,  64'h1111);
        chk("rm.valB",  dif.E_valB,  64'h2222);
        reset = 1'b1; dif.E_bubble = 1'b1;
        step();
        chk_bubble("rst_bub");
        dif.E_bubble = 1'b0;
        step();
        chk_bubble("rst_only");
        reset = 1'b0;

        // mrmovq: srcB=5 forwarded from W_valM while r5 is stale
        set_insn(4'h5, 4'h0, 4'h6, 4'h5);
        dif.r5 = 64'd0;
        dif.W_dstM = 4'h5; dif.W_valM = 64'hAB;
        step();
        chk("wfwd.valB", dif.E_valB, 64'hAB);
        chk("wfwd.srcA", dif.E_srcA, 4'hF);
        chk("wfwd.dstM", dif.E_dstM, 4'h6);
        chk("wfwd.dstE", dif.E_dstE, 4'hF);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/decode_regread.md
# decode_regread

Pipeline decode stage for the Y86-64 processor: the read side of the register file that the writeback stage updates. It takes the fetched instruction held in the D register and computes the source and destination register IDs. It reads operand values from the architectural register outputs r0–r14 and resolves data hazards by forwarding from the E, M and W stages. Results are captured into the E pipeline register, which supports bubble insertion and a synchronous reset.

## Interface
- No parameters; widths fixed: register ID 4 bits, data 64 bits, status 2 bits.
- clock  input  1  sole clock; all state updates on posedge
- reset  input  1  synchronous, active-high; clears the E register to a bubble
- D_stat  input  2  fetch status (0 = AOK)
- D_icode, D_ifun  input  4 each  instruction code and function
- D_rA, D_rB  input  4 each  register specifiers (15 = RNONE)
- D_valC, D_valP  input  64 each  constant word, next PC
- r0 … r14  input  64 each  architectural register values from writeback
- e_dstE  input  4  execute-stage destination; e_valE  input  64  its ALU result
- M_dstE, M_dstM  input  4 each; M_valE  input  64; m_valM  input  64  memory read data
- W_dstE, W_dstM  input  4 each; W_valE, W_valM  input  64 each
- E_bubble  input  1  load a bubble instead of the decoded instruction
- d_srcA, d_srcB  output  4 each  combinational source IDs, for the hazard unit
- E_stat  output  2; E_icode, E_ifun  output  4 each
- E_valC, E_valA, E_valB  output  64 each
- E_dstE, E_dstM, E_srcA, E_srcB  output  4 each

## Operation
- ID decode (combinational, rsp = 4):
  - srcA = rA for icode 2, 4, 6, A; 4 for 9, B; else 15.
  - srcB = rB for 4, 5, 6; 4 for 8, 9, A, B; else 15.
  - dstE = rB for 2, 3, 6; 4 for 8, 9, A, B; else 15.
  - dstM = rA for 5, B; else 15.
  - dstE for cmov (icode 2) is passed unconditioned; execute squashes it.
- Register read: ID n in 0–14 selects rn; ID 15 reads 0.
- valA selection, first match wins:
  1. icode 7 or 8 → D_valP.
  2. srcA == e_dstE → e_valE.
  3. srcA == M_dstM → m_valM.
  4. srcA == M_dstE → M_valE.
  5. srcA == W_dstM → W_valM.
  6. srcA == W_dstE → W_valE.
  7. Otherwise the register read value.
- valB selection: the same chain on srcB, without the valP rule.
- Forwarding is never taken when the src ID is 15, even if a dst is also 15.
- W forwarding is mandatory: writeback updates r0–r14 on the same posedge the E register loads, so the r inputs still hold pre-write values during the cycle.
- E register load:
  - reset = 1, or E_bubble = 1: load the bubble.
  - Otherwise: load D_stat, D_icode, D_ifun, D_valC, the forwarded valA/valB, and the decoded dstE/dstM/srcA/srcB.
- Bubble contents: stat = 0, icode = 1 (nop), ifun = 0, valC = valA = valB = 0, all four IDs = 15.
- reset takes priority over E_bubble. No stall input; holding E is not supported.

## Timing
- Decode, read and forwarding are combinational within the cycle; results appear on the E outputs one posedge later.
- d_srcA and d_srcB are valid in the same cycle as the D inputs.
- Reset value of every E output equals the bubble (E_icode = 1; all IDs = 15; all other fields 0).
- Reset asserted mid-stream discards the in-flight decode. The first real instruction appears on the posedge after reset deasserts with valid D inputs.
- Load-use hazards (the E-stage instruction is mrmovq or popq) are not detected here. The hazard unit asserts E_bubble and stalls F/D externally.

## Test plan
- Reset: hold reset for 2 cycles → E_icode = 1, E_dstE = E_dstM = E_srcA = E_srcB = 15, E_valA = 0. Then OPq 6/0 with rA = 2, rB = 3, r2 = 5, r3 = 7 → next cycle E_valA = 5, E_valB = 7, E_dstE = 3, E_dstM = 15.
- Forward priority: srcA = 2 with e_dstE = 2 (e_valE = 0x11), M_dstM = 2 (m_valM = 0x22), W_dstE = 2 (W_valE = 0x33) → E_valA = 0x11. Drop e_dstE to 15 → 0x22. Drop M_dstM to 15 → 0x33.
- Stack ops: popq (B) rA = 0, r4 = 0x100 → E_srcA = E_srcB = 4, E_valA = E_valB = 0x100, E_dstE = 4, E_dstM = 0. call (8), D_valP = 0x40 → E_valA = 0x40, E_srcA = 15.
- RNONE: irmovq (3) rA = 15, rB = 1, W_dstE = 15, W_valE = 0x99 → E_srcA = 15, E_valA = 0 (no forward), E_dstE = 1.
- Bubble: rmmovq pending with E_bubble = 1 → next cycle the E outputs equal the bubble. reset = 1 together with E_bubble = 1 → also the bubble.
- W same-cycle write: W_dstM = 5, W_valM = 0xAB, r5 = 0 (stale), srcB = 5 → E_valB = 0xAB.
